// File: rtl/litho_seq_pkg.sv
// Shared state encoding, error codes and command decode for the litho exposure sequencer.
package litho_seq_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ENV   = 4'd1,
        RL_LD = 4'd2,
        WL_LD = 4'd3,
        CAL   = 4'd4,
        ALN   = 4'd5,
        SCAN  = 4'd6,
        NEXT  = 4'd7,
        WL_UL = 4'd8,
        RL_UL = 4'd9,
        REL   = 4'd10,
        DONE  = 4'd11,
        ERROR = 4'd12
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ABORT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Command bit order: wl_load, wl_unload, rl_load, rl_unload, ws_calib,
    // ws_align, ws_scan, rs_calib, rs_sync, light_active (MSB first).
    function automatic logic [9:0] cmd_decode(input state_t st);
        case (st)
            RL_LD:   return 10'h080;
            WL_LD:   return 10'h200;
            CAL:     return 10'h024;
            ALN:     return 10'h010;
            SCAN:    return 10'h00B;
            WL_UL:   return 10'h100;
            RL_UL:   return 10'h040;
            default: return 10'h000;
        endcase
    endfunction

    function automatic state_t step_successor(input state_t st);
        case (st)
            ENV:     return RL_LD;
            RL_LD:   return WL_LD;
            WL_LD:   return CAL;
            CAL:     return ALN;
            ALN:     return SCAN;
            SCAN:    return NEXT;
            WL_UL:   return RL_UL;
            RL_UL:   return DONE;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic is_busy(input state_t st);
        return (st != IDLE) && (st != DONE) && (st != ERROR);
    endfunction

    function automatic logic is_wait(input state_t st);
        return is_busy(st) && (st != NEXT);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-step watchdog: counts waiting cycles since the last clear and flags when the limit is reached.
module seq_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;

    // Wait-cycle counter, restarted on every step entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Flags on the cycle whose next edge would be the LIMIT-th wait cycle.
    assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/litho_sequencer.sv
// Wafer-job exposure sequencer driving the loader/stage/light sub-units.
// Optional per-step watchdog enabled by defining SEQ_TIMEOUT_EN.
module litho_sequencer
    import litho_seq_pkg::*;
#(
    parameter int NUM_SHOTS   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       env_ok,
    input  logic       wl_ready,
    input  logic       rl_ready,
    input  logic       ws_done,
    input  logic       rs_done,
    input  logic       source_on,
    output logic       wl_load,
    output logic       wl_unload,
    output logic       rl_load,
    output logic       rl_unload,
    output logic       ws_calib,
    output logic       ws_align,
    output logic       ws_scan,
    output logic       rs_calib,
    output logic       rs_sync,
    output logic       light_active,
    output logic       busy,
    output logic       job_done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [7:0] shot_count,
    output logic [3:0] state
);
    state_t     state_r, state_next_s, ret_r, ret_next_s;
    logic [9:0] cmd_r;
    logic       busy_r, job_done_r, error_r;
    logic [1:0] err_code_r, err_code_next_s;
    logic [7:0] shot_r, shot_inc_s;
    logic       ws_lat_r, rs_lat_r;
    logic       step_ack_s, acks_clear_s, start_acc_s, timeout_s;

    assign start_acc_s  = (state_r == IDLE) && start && !abort;
    assign acks_clear_s = !(wl_ready || rl_ready || ws_done || rs_done || source_on);
    assign shot_inc_s   = (shot_r == 8'hFF) ? shot_r : (shot_r + 8'd1);

`ifdef SEQ_TIMEOUT_EN
    logic step_entry_s;
    assign step_entry_s = (state_next_s != state_r);

    seq_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (step_entry_s),
        .enable  (is_wait(state_r)),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Completion condition of the step currently being held.
    always_comb begin
        step_ack_s = 1'b0;
        case (state_r)
            ENV:          step_ack_s = env_ok;
            RL_LD, RL_UL: step_ack_s = rl_ready;
            WL_LD, WL_UL: step_ack_s = wl_ready;
            CAL:          step_ack_s = (ws_done || ws_lat_r) && (rs_done || rs_lat_r);
            ALN:          step_ack_s = ws_done;
            SCAN:         step_ack_s = ws_done && rs_done && source_on;
            default:      step_ack_s = 1'b0;
        endcase
    end

    // Next-state logic; abort outranks both acks and the watchdog.
    always_comb begin
        state_next_s    = state_r;
        ret_next_s      = ret_r;
        err_code_next_s = err_code_r;
        case (state_r)
            IDLE: begin
                if (start_acc_s) state_next_s = ENV;
                else             state_next_s = IDLE;
            end
            ENV, RL_LD, WL_LD, CAL, ALN, SCAN, WL_UL, RL_UL: begin
                if (step_ack_s) begin
                    state_next_s = REL;
                    ret_next_s   = step_successor(state_r);
                end else begin
                    state_next_s = state_r;
                end
            end
            REL: begin
                if (acks_clear_s) state_next_s = ret_r;
                else              state_next_s = REL;
            end
            NEXT: begin
                if (shot_inc_s == 8'(NUM_SHOTS)) state_next_s = WL_UL;
                else                             state_next_s = ALN;
            end
            DONE, ERROR: state_next_s = IDLE;
            default:     state_next_s = IDLE;
        endcase
        if ((state_r != IDLE) && abort) begin
            state_next_s    = ERROR;
            err_code_next_s = ERR_ABORT;
        end else if (timeout_s) begin
            state_next_s    = ERROR;
            err_code_next_s = ERR_TIMEOUT;
        end else begin
            err_code_next_s = err_code_r;
        end
    end

    // State, registered command/status outputs, ack latches and shot counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            ret_r      <= IDLE;
            cmd_r      <= 10'h000;
            busy_r     <= 1'b0;
            job_done_r <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
            shot_r     <= 8'd0;
            ws_lat_r   <= 1'b0;
            rs_lat_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            ret_r      <= ret_next_s;
            cmd_r      <= cmd_decode(state_next_s);
            busy_r     <= is_busy(state_next_s);
            job_done_r <= (state_next_s == DONE);
            if (start_acc_s) begin
                error_r    <= 1'b0;
                err_code_r <= ERR_NONE;
                shot_r     <= 8'd0;
            end else if ((state_next_s == ERROR) && (state_r != ERROR)) begin
                error_r    <= 1'b1;
                err_code_r <= err_code_next_s;
            end else if (state_r == NEXT) begin
                shot_r <= shot_inc_s;
            end else begin
                shot_r <= shot_r;
            end
            if (state_r == CAL) begin
                ws_lat_r <= ws_lat_r || ws_done;
                rs_lat_r <= rs_lat_r || rs_done;
            end else begin
                ws_lat_r <= 1'b0;
                rs_lat_r <= 1'b0;
            end
        end
    end

    assign {wl_load, wl_unload, rl_load, rl_unload, ws_calib,
            ws_align, ws_scan, rs_calib, rs_sync, light_active} = cmd_r;
    assign busy       = busy_r;
    assign job_done   = job_done_r;
    assign error      = error_r;
    assign err_code   = err_code_r;
    assign shot_count = shot_r;
    assign state      = state_r;

endmodule

// File: tb/tb_litho_sequencer.sv
// Self-checking bench for litho_sequencer with behavioural sub-unit models and job/command scoreboards.
module tb_litho_sequencer;
    localparam int NSHOT = 2;
    localparam logic [3:0] S_IDLE = 4'd0, S_ENV = 4'd1, S_WL_LD = 4'd3, S_CAL = 4'd4,
                           S_SCAN = 4'd6, S_ERROR = 4'd12;
    localparam logic [9:0] C_RL_LD = 10'h080, C_WL_LD = 10'h200, C_CAL = 10'h024,
                           C_ALN = 10'h010, C_SCAN = 10'h00B, C_WL_UL = 10'h100, C_RL_UL = 10'h040;

    typedef struct { logic [7:0] shots; logic [1:0] code; logic err; } job_exp_t;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, env_ok = 1'b1;
    logic wl_ready = 1'b0, rl_ready = 1'b0, ws_done = 1'b0, rs_done = 1'b0, source_on = 1'b0;
    logic wl_load, wl_unload, rl_load, rl_unload, ws_calib, ws_align, ws_scan;
    logic rs_calib, rs_sync, light_active, busy, job_done, error;
    logic [1:0] err_code;
    logic [7:0] shot_count;
    logic [3:0] state;
    logic [9:0] cmd_v;

    job_exp_t   job_q[$];
    logic [9:0] cmd_q[$];
    job_exp_t   mon_e;
    logic [9:0] prev_cmd = 10'h000;
    logic [3:0] prev_state = 4'd0;
    int n_checks = 0, n_fail = 0, cyc = 0, cal_cyc = 0, err_cyc = 0;
    int wl_dly = 3, rl_dly = 3, ws_dly = 2, rs_dly = 2, src_dly = 1;
    int wl_cnt = 0, rl_cnt = 0, ws_cnt = 0, rs_cnt = 0, src_cnt = 0;
    bit ws_stuck = 1'b0, rs_pulse = 1'b0;

    litho_sequencer #(.NUM_SHOTS(NSHOT), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .env_ok(env_ok),
        .wl_ready(wl_ready), .rl_ready(rl_ready), .ws_done(ws_done), .rs_done(rs_done),
        .source_on(source_on), .wl_load(wl_load), .wl_unload(wl_unload), .rl_load(rl_load),
        .rl_unload(rl_unload), .ws_calib(ws_calib), .ws_align(ws_align), .ws_scan(ws_scan),
        .rs_calib(rs_calib), .rs_sync(rs_sync), .light_active(light_active), .busy(busy),
        .job_done(job_done), .error(error), .err_code(err_code), .shot_count(shot_count),
        .state(state)
    );

    assign cmd_v = {wl_load, wl_unload, rl_load, rl_unload, ws_calib,
                    ws_align, ws_scan, rs_calib, rs_sync, light_active};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bump(input int c);
        return (c < 1000) ? c + 1 : c;
    endfunction

    // Sub-unit models: ack after a programmable delay while commanded, drop with the command.
    always @(negedge clk) begin
        if (wl_load || wl_unload) begin wl_cnt = bump(wl_cnt); wl_ready = (wl_cnt >= wl_dly); end
        else begin wl_cnt = 0; wl_ready = 1'b0; end
        if (rl_load || rl_unload) begin rl_cnt = bump(rl_cnt); rl_ready = (rl_cnt >= rl_dly); end
        else begin rl_cnt = 0; rl_ready = 1'b0; end
        if (ws_calib || ws_align || ws_scan) begin
            ws_cnt = bump(ws_cnt); ws_done = (ws_cnt >= ws_dly) && !ws_stuck;
        end else begin ws_cnt = 0; ws_done = 1'b0; end
        if (rs_calib || rs_sync) begin
            rs_cnt  = bump(rs_cnt);
            rs_done = (rs_pulse && rs_calib) ? (rs_cnt == rs_dly) : (rs_cnt >= rs_dly);
        end else begin rs_cnt = 0; rs_done = 1'b0; end
        if (light_active) begin src_cnt = bump(src_cnt); source_on = (src_cnt >= src_dly); end
        else begin src_cnt = 0; source_on = 1'b0; end
    end

    // Scoreboard monitor: command order/gaps and end-of-job status.
    always @(negedge clk) begin
        cyc++;
        if ((cmd_v != prev_cmd) && (cmd_v != 10'h000)) begin
            check_eq("cmd_gap", {22'd0, prev_cmd}, 32'd0);
            if (cmd_q.size() > 0) check_eq("cmd_seq", {22'd0, cmd_v}, {22'd0, cmd_q.pop_front()});
            else                  check_eq("cmd_extra", {22'd0, cmd_v}, 32'd0);
        end
        if ((state == S_CAL) && (prev_state != S_CAL)) cal_cyc = cyc;
        if (job_done || ((state == S_ERROR) && (prev_state != S_ERROR))) begin
            if (state == S_ERROR) err_cyc = cyc;
            if (job_q.size() > 0) begin
                mon_e = job_q.pop_front();
                check_eq("end_shots", {24'd0, shot_count}, {24'd0, mon_e.shots});
                check_eq("end_code", {30'd0, err_code}, {30'd0, mon_e.code});
                check_eq("end_error", {31'd0, error}, {31'd0, mon_e.err});
                check_eq("end_done", {31'd0, job_done}, {31'd0, !mon_e.err});
                check_eq("end_cmds_left", cmd_q.size(), 32'd0);
            end else begin
                check_eq("end_unexpected", 32'd1, 32'd0);
            end
        end
        prev_cmd   = cmd_v;
        prev_state = state;
    end

    task automatic push_job(input int n_scan, input bit full, input logic [7:0] shots,
                            input logic [1:0] code, input logic err);
        job_exp_t e;
        cmd_q.push_back(C_RL_LD); cmd_q.push_back(C_WL_LD); cmd_q.push_back(C_CAL);
        for (int i = 0; i < n_scan; i++) begin cmd_q.push_back(C_ALN); cmd_q.push_back(C_SCAN); end
        if (full) begin cmd_q.push_back(C_WL_UL); cmd_q.push_back(C_RL_UL); end
        e.shots = shots; e.code = code; e.err = err;
        job_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
        bit hit = 1'b0;
        for (int i = 0; (i < budget) && !hit; i++) begin
            @(negedge clk);
            hit = (state == st);
        end
        check_eq({tag, "_reached"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic nominal_job(input string tag);
        push_job(NSHOT, 1'b1, 8'(NSHOT), 2'd0, 1'b0);
        pulse_start();
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_state(tag, S_IDLE, 400);
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        check_eq("rst_state", {28'd0, state}, 32'd0);
        check_eq("rst_cmds", {22'd0, cmd_v}, 32'd0);
        check_eq("rst_status", {27'd0, busy, job_done, error, err_code}, 32'd0);
        check_eq("rst_shots", {24'd0, shot_count}, 32'd0);
        reset_n = 1'b1;

        // 1: nominal job
        nominal_job("t1");
        check_eq("t1_shots_hold", {24'd0, shot_count}, NSHOT);
        check_eq("t1_error", {31'd0, error}, 32'd0);

        // 2: start during environment warm-up
        env_ok = 1'b0;
        push_job(NSHOT, 1'b1, 8'(NSHOT), 2'd0, 1'b0);
        pulse_start();
        repeat (8) @(negedge clk);
        check_eq("t2_env_hold", {28'd0, state}, {28'd0, S_ENV});
        check_eq("t2_env_cmds", {22'd0, cmd_v}, 32'd0);
        env_ok = 1'b1;
        wait_state("t2", S_IDLE, 400);

        // 3: abort during the second scan, then a clean job
        push_job(2, 1'b0, 8'd1, 2'd1, 1'b1);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; (i < 400) && !hit; i++) begin
            @(negedge clk);
            hit = (state == S_SCAN) && (shot_count == 8'd1);
        end
        check_eq("t3_scan2_reached", {31'd0, hit}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t3_cmds_off", {22'd0, cmd_v}, 32'd0);
        check_eq("t3_state", {28'd0, state}, {28'd0, S_ERROR});
        check_eq("t3_busy", {31'd0, busy}, 32'd0);
        wait_state("t3", S_IDLE, 10);
        push_job(NSHOT, 1'b1, 8'(NSHOT), 2'd0, 1'b0);
        pulse_start();
        check_eq("t3_err_cleared", {29'd0, error, err_code}, 32'd0);
        wait_state("t3b", S_IDLE, 400);

        // 4: wafer stage never acknowledges calibration
        ws_stuck = 1'b1;
`ifdef SEQ_TIMEOUT_EN
        push_job(0, 1'b0, 8'd0, 2'd2, 1'b1);
        pulse_start();
        wait_state("t4_cal", S_CAL, 100);
        wait_state("t4_err", S_ERROR, 40);
        @(negedge clk);
        check_eq("t4_timeout_cycles", err_cyc - cal_cyc, 32'd16);
`else
        push_job(0, 1'b0, 8'd0, 2'd1, 1'b1);
        pulse_start();
        wait_state("t4_cal", S_CAL, 100);
        repeat (40) @(negedge clk);
        check_eq("t4_cal_hold", {28'd0, state}, {28'd0, S_CAL});
        check_eq("t4_cal_cmds", {22'd0, cmd_v}, {22'd0, C_CAL});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif
        ws_stuck = 1'b0;
        wait_state("t4", S_IDLE, 10);

        // 5: reticle stage acks (one-cycle pulse) three cycles ahead of wafer stage
        rs_pulse = 1'b1; rs_dly = 1; ws_dly = 4;
        push_job(NSHOT, 1'b1, 8'(NSHOT), 2'd0, 1'b0);
        pulse_start();
        wait_state("t5_cal", S_CAL, 100);
        #1;
        check_eq("t5_rs_first", {30'd0, rs_done, ws_done}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check_eq("t5_cal_hold", {28'd0, state}, {28'd0, S_CAL});
        end
        check_eq("t5_ws_late", {30'd0, rs_done, ws_done}, 32'd1);
        wait_state("t5", S_IDLE, 400);
        rs_pulse = 1'b0; rs_dly = 2; ws_dly = 2;

        // 6: reset mid wafer load, then a fresh job
        push_job(NSHOT, 1'b1, 8'(NSHOT), 2'd0, 1'b0);
        pulse_start();
        wait_state("t6_wl", S_WL_LD, 100);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_async_clear",
                 {5'd0, cmd_v, busy, job_done, error, err_code, shot_count, state}, 32'd0);
        cmd_q.delete();
        job_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        nominal_job("t6");

        check_eq("queues_empty", job_q.size() + cmd_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
